// File: rtl/player_bullet.sv
// Player shot unit: launches one bullet from the ship centre, steps it up per frame tick,
// retires it on enemy hit or top border. Optional cooldown state: PLAYER_BULLET_COOLDOWN_EN.
module player_bullet #(
  parameter logic [9:0] start_y_p  = 10'd440,
  parameter logic [9:0] top_y_p    = 10'd8,
  parameter logic [9:0] step_p     = 10'd4,
  parameter logic [9:0] x_offset_p = 10'd17,
  parameter logic [3:0] cooldown_p = 4'd6
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       frame_tick_i,
  input  logic       freeze_i,
  input  logic       alive_i,
  input  logic       shoot_i,
  input  logic [9:0] player_left_i,
  input  logic       enemy_hit_i,
  output logic       active_o,
  output logic [9:0] bullet_x_o,
  output logic [9:0] bullet_y_o,
  output logic       hit_o,
  output logic       miss_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    FLYING = 3'b010,
    COOL   = 3'b100
  } state_e;

  // Below this y the bullet cannot take another step without crossing the border.
  localparam logic [9:0] retire_y_p = top_y_p + step_p;

`ifdef PLAYER_BULLET_COOLDOWN_EN
  localparam state_e retire_state = COOL;
  logic [3:0] cool_cnt_q;
`else
  localparam state_e retire_state = IDLE;
  logic unused_cooldown;
  assign unused_cooldown = ^cooldown_p;
`endif

  state_e state_q;
  logic   shoot_q;
  logic   fire_req;

  assign fire_req = shoot_i & ~shoot_q;
  assign state_o  = state_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      shoot_q    <= 1'b1;
      active_o   <= 1'b0;
      bullet_x_o <= 10'd0;
      bullet_y_o <= start_y_p;
      hit_o      <= 1'b0;
      miss_o     <= 1'b0;
`ifdef PLAYER_BULLET_COOLDOWN_EN
      cool_cnt_q <= 4'd0;
`endif
    end else begin
      shoot_q <= shoot_i;
      hit_o   <= 1'b0;
      miss_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fire_req && alive_i && !freeze_i) begin
            state_q    <= FLYING;
            active_o   <= 1'b1;
            bullet_x_o <= player_left_i + x_offset_p;
            bullet_y_o <= start_y_p;
          end
        end
        FLYING: begin
          if (!alive_i) begin
            state_q  <= IDLE;
            active_o <= 1'b0;
          end else if (freeze_i) begin
            state_q <= FLYING;
          end else if (enemy_hit_i) begin
            state_q  <= retire_state;
            active_o <= 1'b0;
            hit_o    <= 1'b1;
`ifdef PLAYER_BULLET_COOLDOWN_EN
            cool_cnt_q <= cooldown_p;
`endif
          end else if (frame_tick_i) begin
            if (bullet_y_o < retire_y_p) begin
              state_q  <= retire_state;
              active_o <= 1'b0;
              miss_o   <= 1'b1;
`ifdef PLAYER_BULLET_COOLDOWN_EN
              cool_cnt_q <= cooldown_p;
`endif
            end else begin
              bullet_y_o <= bullet_y_o - step_p;
            end
          end
        end
`ifdef PLAYER_BULLET_COOLDOWN_EN
        COOL: begin
          if (!alive_i) begin
            state_q    <= IDLE;
            cool_cnt_q <= 4'd0;
          end else if (frame_tick_i && !freeze_i) begin
            if (cool_cnt_q <= 4'd1) begin
              state_q    <= IDLE;
              cool_cnt_q <= 4'd0;
            end else begin
              cool_cnt_q <= cool_cnt_q - 4'd1;
            end
          end
        end
`endif
        default: begin
          state_q  <= IDLE;
          active_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_bullet.sv
// Directed bench for player_bullet: vector table plus hand-written flight sequences.
module tb_player_bullet;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       frame_tick_i, freeze_i, alive_i, shoot_i, enemy_hit_i;
  logic [9:0] player_left_i;
  logic       active_o, hit_o, miss_o;
  logic [9:0] bullet_x_o, bullet_y_o;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  player_bullet dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .frame_tick_i(frame_tick_i),
    .freeze_i(freeze_i), .alive_i(alive_i), .shoot_i(shoot_i),
    .player_left_i(player_left_i), .enemy_hit_i(enemy_hit_i),
    .active_o(active_o), .bullet_x_o(bullet_x_o), .bullet_y_o(bullet_y_o),
    .hit_o(hit_o), .miss_o(miss_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       sh, al, fr, tk, eh;
    logic [9:0] left;
    logic       act;
    logic [9:0] x, y;
    logic       h, m;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sh, input logic al, input logic fr, input logic tk,
                     input logic eh, input logic [9:0] left, input logic act,
                     input logic [9:0] x, input logic [9:0] y, input logic h,
                     input logic m, input logic [2:0] st);
    vec_t v;
    v.sh = sh; v.al = al; v.fr = fr; v.tk = tk; v.eh = eh; v.left = left;
    v.act = act; v.x = x; v.y = y; v.h = h; v.m = m; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic act, input logic [9:0] x,
                         input logic [9:0] y, input logic h, input logic m,
                         input logic [2:0] st);
    n_tests++;
    if (active_o !== act || bullet_x_o !== x || bullet_y_o !== y ||
        hit_o !== h || miss_o !== m || state_o !== st) begin
      n_fail++;
      $display("FAIL %s: got act=%0b x=%0d y=%0d hit=%0b miss=%0b st=%b, expected act=%0b x=%0d y=%0d hit=%0b miss=%0b st=%b",
               name, active_o, bullet_x_o, bullet_y_o, hit_o, miss_o, state_o,
               act, x, y, h, m, st);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic sh, input logic al, input logic fr, input logic tk,
                     input logic eh);
    shoot_i = sh; alive_i = al; freeze_i = fr; frame_tick_i = tk; enemy_hit_i = eh;
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    reset_n_i = 1'b0; shoot_i = 1'b1; alive_i = 1'b1; freeze_i = 1'b0;
    frame_tick_i = 1'b0; enemy_hit_i = 1'b0; player_left_i = 10'd250;
    #12;
    chk_all("reset", 1'b0, 10'd0, 10'd440, 1'b0, 1'b0, 3'b001);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;

`ifndef PLAYER_BULLET_COOLDOWN_EN
    //   sh    al    fr    tk    eh    left     act   x        y        h     m     st
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd250, 1'b0, 10'd0,   10'd440, 1'b0, 1'b0, 3'b001);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd250, 1'b0, 10'd0,   10'd440, 1'b0, 1'b0, 3'b001);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd250, 1'b1, 10'd267, 10'd440, 1'b0, 1'b0, 3'b010);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'd250, 1'b1, 10'd267, 10'd436, 1'b0, 1'b0, 3'b010);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd250, 1'b1, 10'd267, 10'd432, 1'b0, 1'b0, 3'b010);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'd300, 1'b1, 10'd267, 10'd428, 1'b0, 1'b0, 3'b010);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd300, 1'b1, 10'd267, 10'd428, 1'b0, 1'b0, 3'b010);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd300, 1'b1, 10'd267, 10'd428, 1'b0, 1'b0, 3'b010);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd300, 1'b1, 10'd267, 10'd424, 1'b0, 1'b0, 3'b010);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'd300, 1'b0, 10'd267, 10'd424, 1'b1, 1'b0, 3'b001);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd300, 1'b0, 10'd267, 10'd424, 1'b0, 1'b0, 3'b001);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 1'b1, 10'd117, 10'd440, 1'b0, 1'b0, 3'b010);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd100, 1'b0, 10'd117, 10'd440, 1'b0, 1'b0, 3'b001);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd100, 1'b0, 10'd117, 10'd440, 1'b0, 1'b0, 3'b001);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 1'b0, 10'd117, 10'd440, 1'b0, 1'b0, 3'b001);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100, 1'b0, 10'd117, 10'd440, 1'b0, 1'b0, 3'b001);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 1'b0, 10'd117, 10'd440, 1'b0, 1'b0, 3'b001);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 1'b1, 10'd117, 10'd440, 1'b0, 1'b0, 3'b010);

    for (int i = 0; i < vecs.size(); i++) begin
      player_left_i = vecs[i].left;
      cyc(vecs[i].sh, vecs[i].al, vecs[i].fr, vecs[i].tk, vecs[i].eh);
      chk_all($sformatf("vec%0d", i), vecs[i].act, vecs[i].x, vecs[i].y,
              vecs[i].h, vecs[i].m, vecs[i].st);
    end

    // Full climb to the top border, then a miss.
    ticks(108);
    chk_all("climb_to_top", 1'b1, 10'd117, 10'd8, 1'b0, 1'b0, 3'b010);
    ticks(1);
    chk_all("top_miss", 1'b0, 10'd117, 10'd8, 1'b0, 1'b1, 3'b001);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("refire_after_miss", 1'b1, 10'd117, 10'd440, 1'b0, 1'b0, 3'b010);

    // Hit and top border in the same cycle count as a hit only.
    ticks(108);
    chk("y_at_top", bullet_y_o, 8);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk_all("hit_beats_miss", 1'b0, 10'd117, 10'd8, 1'b1, 1'b0, 3'b001);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("hit_one_cycle", 1'b0, 10'd117, 10'd8, 1'b0, 1'b0, 3'b001);

    // Hit mid-screen at y=200.
    player_left_i = 10'd250;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(60);
    chk_all("y200", 1'b1, 10'd267, 10'd200, 1'b0, 1'b0, 3'b010);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_all("hit_y200", 1'b0, 10'd267, 10'd200, 1'b1, 1'b0, 3'b001);

    // Freeze for 10 ticks with enemy_hit noise.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5);
    chk("pre_freeze_y", bullet_y_o, 420);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'(i % 2));
      chk_all($sformatf("freeze%0d", i), 1'b1, 10'd267, 10'd420, 1'b0, 1'b0, 3'b010);
    end
    ticks(1);
    chk("resume_y", bullet_y_o, 416);

    // Asynchronous reset mid-flight.
    #2;
    reset_n_i = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 10'd0, 10'd440, 1'b0, 1'b0, 3'b001);
    @(negedge clk_i);
    reset_n_i = 1'b1;
`else
    // Cooldown build: hit, then presses on ticks 1..5 are ignored; launch after tick 6.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("cd_launch", 1'b1, 10'd267, 10'd440, 1'b0, 1'b0, 3'b010);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_all("cd_hit", 1'b0, 10'd267, 10'd440, 1'b1, 1'b0, 3'b100);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk_all($sformatf("cd_tick%0d", i), 1'b0, 10'd267, 10'd440, 1'b0, 1'b0, 3'b100);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("cd_done", 1'b0, 10'd267, 10'd440, 1'b0, 1'b0, 3'b001);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("cd_relaunch", 1'b1, 10'd267, 10'd440, 1'b0, 1'b0, 3'b010);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/player_bullet.md
Name: player_bullet

Overview:
- Player shot unit, directly downstream of the player ship block.
- Takes the ship's left position, alive flag and shoot button, and launches a single bullet from the ship's centre.
- Steps the bullet upward once per frame tick and retires it on an enemy hit or at the top border.
- Outputs bullet position for the renderer, plus hit/miss pulses for the score and enemy logic.

Parameters:
- start_y_p, 10'd440, bullet y loaded at launch (just above the ship).
- top_y_p, 10'd8, top border; the bullet retires when it cannot step without going below this value.
- step_p, 10'd4, pixels moved per frame tick.
- x_offset_p, 10'd17, added to player_left_i to centre the bullet on the 36-pixel-wide ship.
- cooldown_p, 4'd6, frame ticks of cooldown (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- frame_tick_i  in  1  one-cycle pulse per video frame
- freeze_i  in  1  game paused (player hit / level transition)
- alive_i  in  1  player alive flag from the player ship
- shoot_i  in  1  shoot button level, already debounced
- player_left_i  in  10  left-most x of the ship
- enemy_hit_i  in  1  collision from the enemy grid for the current bullet position
- active_o  out  1  bullet in flight; the renderer draws it only when high
- bullet_x_o  out  10  bullet x
- bullet_y_o  out  10  bullet y (top edge)
- hit_o  out  1  one-cycle pulse: bullet struck an enemy
- miss_o  out  1  one-cycle pulse: bullet reached the top border
- state_o  out  3  present state (one-hot), for debug

Behaviour:
- Reset (async, reset_n_i=0):
  - state IDLE; active_o=0, bullet_x_o=0, bullet_y_o=start_y_p, hit_o=0, miss_o=0.
  - Internal shoot_q resets to 1, so a button already held through reset does not fire.
- Edge detect: fire_req = shoot_i & ~shoot_q. shoot_q <= shoot_i every cycle.
- States (one-hot): IDLE=3'b001, FLYING=3'b010, COOL=3'b100.
- IDLE:
  - If fire_req & alive_i & ~freeze_i: next cycle state=FLYING, active_o=1.
  - bullet_x_o latches player_left_i + x_offset_p (10-bit, truncating) and bullet_y_o latches start_y_p.
  - x stays frozen for the whole flight.
  - All other cases: hold IDLE.
- FLYING, priority high to low:
  1. ~alive_i: go to IDLE, active_o=0, no pulse.
  2. freeze_i: hold position and state; enemy_hit_i and frame_tick_i are ignored.
  3. enemy_hit_i: hit_o=1 for exactly one cycle, active_o=0, go to IDLE (or COOL).
  4. frame_tick_i:
     - If bullet_y_o < top_y_p + step_p: miss_o=1 for one cycle, active_o=0, go to IDLE (or COOL).
     - Else bullet_y_o <= bullet_y_o - step_p.
- A hit and a top-border condition in the same cycle count as a hit only; miss_o stays 0.
- Latency: the hit_o and miss_o pulses assert in the cycle after the triggering input is sampled (registered outputs).
- fire_req during FLYING or COOL is dropped, not queued. Only one bullet is ever in flight.
- Without the optional feature, COOL is unreachable; retirement goes straight to IDLE. An illegal state decodes to IDLE.
- hit_o and miss_o are never high together. Neither asserts while active_o=0, except in the pulse cycle itself.

Optional Feature:
- Macro PLAYER_BULLET_COOLDOWN_EN.
- Defined:
  - After hit or miss, the state goes to COOL and a 4-bit counter loads cooldown_p.
  - The counter decrements on each frame_tick_i that arrives while ~freeze_i.
  - When the counter reaches 0, the state returns to IDLE.
  - fire_req is ignored throughout COOL.
  - ~alive_i forces COOL to IDLE immediately.
- Undefined: no counter and no COOL state; retirement returns to IDLE, so the next fire can be accepted on the cycle after retirement.

Test Plan:
- Launch: reset, player_left_i=250, alive_i=1, pulse shoot_i → active_o=1, bullet_x_o=267, bullet_y_o=440; after 3 frame ticks bullet_y_o=428.
- Top miss: fire, then 108 frame ticks → y steps 440→8. The next tick gives a one-cycle miss_o pulse, active_o=0, hit_o=0.
- Hit, and hit/miss collision: at y=200 assert enemy_hit_i for one cycle → hit_o pulses once, active_o=0. With y=8, assert enemy_hit_i together with frame_tick_i → hit_o=1, miss_o=0.
- Rejection:
  - shoot_i held high from reset → no launch until released and re-pressed.
  - Pressing while FLYING → no second launch; x unchanged when player_left_i moves.
- Freeze/death:
  - freeze_i=1 for 10 ticks mid-flight → y constant, enemy_hit_i ignored; flight resumes after release.
  - alive_i=0 mid-flight → active_o=0 next cycle with no hit_o or miss_o.
  - Asserting reset_n_i mid-flight returns all outputs to reset values asynchronously.
- Cooldown (macro defined, cooldown_p=6): after a hit, press shoot at ticks 1–5 → ignored; after 6 ticks a press launches.
